// File: rtl/fft32_reorder_buf.sv
// fft32_reorder_buf
// -----------------
// Output stage of the 32-point FFT. It takes the two-lane, bit-reversed pairs
// from the MDC core and emits one natural-order sample per cycle.
//
// A ping-pong pair of frame buffers is used. Each buffer holds N entries of
// {Re, Im}, split into a LO bank (0..N/2-1) and a HI bank (N/2..N-1). The k-th
// accepted pair writes LO[bitrev(k)] and HI[bitrev(k)] on the same edge.
//
// Handshake: valid-only, with no backpressure. A pair is presented on every
// edge where MDC_out_valid = 1. If the write-target buffer cannot take the
// pair, it is dropped and the sticky o_overflow flag is set. FFT_out_valid
// qualifies FFTOutRe/FFTOutIm for exactly one cycle per sample.
//
// Optional feature, macro REORDER_SOF_EN:
//   Adds the FFT_out_sof output. It is 1 on the cycle where X[0] of a frame
//   is valid.
//
// Ports:
//   clk, i_rst            clock; synchronous active-high reset
//   MDCOutUp{Re,Im}       upper-lane sample = X[bitrev(k)]
//   MDCOutDown{Re,Im}     lower-lane sample = X[N/2 + bitrev(k)]
//   MDC_out_valid         input pair valid this cycle
//   FFTOut{Re,Im}         natural-order output sample (registered)
//   FFT_out_valid         output sample valid
//   FFT_out_sof           (REORDER_SOF_EN only) first sample of a frame
//   o_overflow            sticky: a pair was dropped (cleared by reset)
//   dbg_buf_state         {state of buffer 1, state of buffer 0}
module fft32_reorder_buf #(
  parameter int DATA_W = 11,
  parameter int LOG2N  = 5
) (
  input  logic                     clk,
  input  logic                     i_rst,
  input  logic signed [DATA_W-1:0] MDCOutUpRe,
  input  logic signed [DATA_W-1:0] MDCOutUpIm,
  input  logic signed [DATA_W-1:0] MDCOutDownRe,
  input  logic signed [DATA_W-1:0] MDCOutDownIm,
  input  logic                     MDC_out_valid,
  output logic signed [DATA_W-1:0] FFTOutRe,
  output logic signed [DATA_W-1:0] FFTOutIm,
  output logic                     FFT_out_valid,
`ifdef REORDER_SOF_EN
  output logic                     FFT_out_sof,
`endif
  output logic                     o_overflow,
  output logic [3:0]               dbg_buf_state
);

  localparam int HALF = 1 << (LOG2N - 1);
  localparam logic [LOG2N-2:0] WR_ONE = 1;
  localparam logic [LOG2N-1:0] RD_ONE = 1;

  typedef enum logic [1:0] {
    BUF_EMPTY    = 2'd0,
    BUF_FILLING  = 2'd1,
    BUF_FULL     = 2'd2,
    BUF_DRAINING = 2'd3
  } buf_state_t;

  buf_state_t buf_state     [2];
  buf_state_t buf_state_nxt [2];

  logic             wr_sel;
  logic             rd_sel;
  logic [LOG2N-2:0] wr_cnt;
  logic [LOG2N-1:0] rd_cnt;

  logic [2*DATA_W-1:0] mem_lo [2][HALF];
  logic [2*DATA_W-1:0] mem_hi [2][HALF];

  logic                can_read;
  logic                rd_last;
  logic                wr_free;
  logic                accept;
  logic                drop;
  logic                wr_last;
  logic [LOG2N-2:0]    wr_addr;
  logic [2*DATA_W-1:0] rd_data;

  function automatic logic [LOG2N-2:0] bitrev(input logic [LOG2N-2:0] v);
    logic [LOG2N-2:0] r;
    for (int i = 0; i < LOG2N - 1; i++) r[i] = v[LOG2N-2-i];
    return r;
  endfunction

  assign dbg_buf_state = {buf_state[1], buf_state[0]};
  assign wr_addr       = bitrev(wr_cnt);

  // Next-state logic for both buffers. The read effect is applied first,
  // then the write effect. The two can only target the same buffer when its
  // final read (index N-1) completes on the same edge that a new pair
  // arrives. In that case the buffer goes straight to FILLING, and the new
  // pair is written as k = 0.
  always_comb begin
    buf_state_nxt[0] = buf_state[0];
    buf_state_nxt[1] = buf_state[1];
    can_read = (buf_state[rd_sel] == BUF_FULL) || (buf_state[rd_sel] == BUF_DRAINING);
    rd_last  = can_read && (rd_cnt == '1);
    wr_free  = (buf_state[wr_sel] == BUF_EMPTY) || (buf_state[wr_sel] == BUF_FILLING)
               || (rd_last && (rd_sel == wr_sel));
    accept   = MDC_out_valid && wr_free;
    drop     = MDC_out_valid && !wr_free;
    wr_last  = (wr_cnt == '1);
    rd_data  = rd_cnt[LOG2N-1] ? mem_hi[rd_sel][rd_cnt[LOG2N-2:0]]
                               : mem_lo[rd_sel][rd_cnt[LOG2N-2:0]];
    if (can_read) buf_state_nxt[rd_sel] = rd_last ? BUF_EMPTY : BUF_DRAINING;
    if (accept)   buf_state_nxt[wr_sel] = wr_last ? BUF_FULL : BUF_FILLING;
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      buf_state[0]  <= BUF_EMPTY;
      buf_state[1]  <= BUF_EMPTY;
      wr_sel        <= 1'b0;
      rd_sel        <= 1'b0;
      wr_cnt        <= '0;
      rd_cnt        <= '0;
      FFTOutRe      <= '0;
      FFTOutIm      <= '0;
      FFT_out_valid <= 1'b0;
      o_overflow    <= 1'b0;
`ifdef REORDER_SOF_EN
      FFT_out_sof   <= 1'b0;
`endif
    end else begin
      buf_state[0] <= buf_state_nxt[0];
      buf_state[1] <= buf_state_nxt[1];
      if (accept) begin
        wr_cnt <= wr_cnt + WR_ONE;
        if (wr_last) wr_sel <= ~wr_sel;
      end
      if (drop) o_overflow <= 1'b1;
      // When nothing is ready to read, only the valid strobe drops.
      // The data outputs keep their last value.
      if (can_read) begin
        FFTOutRe      <= rd_data[2*DATA_W-1:DATA_W];
        FFTOutIm      <= rd_data[DATA_W-1:0];
        FFT_out_valid <= 1'b1;
        rd_cnt        <= rd_cnt + RD_ONE;
        if (rd_last) rd_sel <= ~rd_sel;
      end else begin
        FFT_out_valid <= 1'b0;
      end
`ifdef REORDER_SOF_EN
      FFT_out_sof <= can_read && (rd_cnt == '0);
`endif
    end
  end

  // Frame storage has no reset. Stale contents are never read, because a
  // buffer only becomes readable after all N/2 pairs have been rewritten.
  always_ff @(posedge clk) begin
    if (!i_rst && accept) begin
      mem_lo[wr_sel][wr_addr] <= {MDCOutUpRe, MDCOutUpIm};
      mem_hi[wr_sel][wr_addr] <= {MDCOutDownRe, MDCOutDownIm};
    end
  end

endmodule

// File: tb/tb_fft32_reorder_buf.sv
// Testbench for fft32_reorder_buf: directed frames, with a scoreboard queue
// of expected natural-order samples.
module tb_fft32_reorder_buf;

  localparam int DATA_W = 11;
  localparam int LOG2N  = 5;
  localparam int EW     = 2 * DATA_W + 1;

`ifdef REORDER_SOF_EN
  localparam bit SOF_EN = 1'b1;
`else
  localparam bit SOF_EN = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     i_rst;
  logic signed [DATA_W-1:0] up_re, up_im, dn_re, dn_im;
  logic                     in_valid;
  logic signed [DATA_W-1:0] out_re, out_im;
  logic                     out_valid;
  logic                     sof_obs;
  logic                     overflow;
  logic [3:0]               dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int run      = 0;
  int last_run = 0;

  logic [EW-1:0] exp_q[$];

  fft32_reorder_buf #(.DATA_W(DATA_W), .LOG2N(LOG2N)) dut (
    .clk           (clk),
    .i_rst         (i_rst),
    .MDCOutUpRe    (up_re),
    .MDCOutUpIm    (up_im),
    .MDCOutDownRe  (dn_re),
    .MDCOutDownIm  (dn_im),
    .MDC_out_valid (in_valid),
    .FFTOutRe      (out_re),
    .FFTOutIm      (out_im),
    .FFT_out_valid (out_valid),
`ifdef REORDER_SOF_EN
    .FFT_out_sof   (sof_obs),
`endif
    .o_overflow    (overflow),
    .dbg_buf_state (dbg_state)
  );

`ifndef REORDER_SOF_EN
  assign sof_obs = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish, required finish before 200000");
    $fatal(1, "timeout");
  end

  // ---------------- helpers ----------------
  function automatic int bitrev4(input int k);
    return ((k & 1) << 3) | ((k & 2) << 1) | ((k & 4) >> 1) | ((k & 8) >> 3);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input int base);
    logic [DATA_W-1:0] re, im;
    for (int i = 0; i < 32; i++) begin
      re = DATA_W'(base + i);
      im = DATA_W'(-(base + i));
      exp_q.push_back({SOF_EN && (i == 0), re, im});
    end
  endtask

  // Drives 16 pairs. Each pair is sampled on the next posedge. When gapped
  // is set, an idle cycle follows every pair except the last one.
  task automatic drive_frame(input int base, input bit gapped, input bit push);
    int br;
    if (push) push_frame(base);
    for (int k = 0; k < 16; k++) begin
      br       = bitrev4(k);
      up_re    = DATA_W'(base + br);
      up_im    = DATA_W'(-(base + br));
      dn_re    = DATA_W'(base + 16 + br);
      dn_im    = DATA_W'(-(base + 16 + br));
      in_valid = 1'b1;
      @(posedge clk); #1;
      if (gapped && k != 15) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(posedge clk); #1;
    end
  endtask

  // Called right after the last pair's edge t. Output must still be idle
  // after edge t, and X[0] must be valid after edge t+1.
  task automatic check_latency(input string tag);
    @(negedge clk);
    check({tag, "_idle_before"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({tag, "_x0_valid"}, 32'(out_valid), 32'd1);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && out_valid !== 1'b1) break;
    end
    @(negedge clk);
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (out_valid === 1'b1) begin
      run++;
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_output: observed re=%0d with empty queue, expected no output", out_re);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_checks++;
        assert ({sof_obs, out_re, out_im} === e) else begin
          n_fail++;
          $error("FAIL sample: observed sof=%0b re=%0d im=%0d expected sof=%0b re=%0d im=%0d",
                 sof_obs, out_re, out_im, e[EW-1],
                 $signed(e[2*DATA_W-1:DATA_W]), $signed(e[DATA_W-1:0]));
        end
      end
    end else begin
      if (run != 0) last_run = run;
      run = 0;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    bit hit;
    i_rst = 1'b1; in_valid = 1'b0;
    up_re = '0; up_im = '0; dn_re = '0; dn_im = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_re", 32'(out_re), 32'd0);
    check("reset_im", 32'(out_im), 32'd0);
    check("reset_ovf", 32'(overflow), 32'd0);
    check("reset_state", 32'(dbg_state), 32'd0);
    check("reset_sof", 32'(sof_obs), 32'd0);
    i_rst = 1'b0;

    // Single contiguous frame
    drive_frame(0, 1'b0, 1'b1);
    check_latency("single");
    wait_drain("single");
    check("single_run", 32'(last_run), 32'd32);

    // Gapped frame
    drive_frame(0, 1'b1, 1'b1);
    check_latency("gapped");
    wait_drain("gapped");
    check("gapped_run", 32'(last_run), 32'd32);

    // Back-to-back frames at 32-cycle spacing
    drive_frame(0, 1'b0, 1'b1);
    idle(16);
    drive_frame(100, 1'b0, 1'b1);
    wait_drain("b2b");
    check("b2b_run", 32'(last_run), 32'd64);
    check("b2b_no_ovf", 32'(overflow), 32'd0);

    // Overflow: three frames at 16-cycle spacing. The third frame is lost.
    drive_frame(0, 1'b0, 1'b1);
    drive_frame(300, 1'b0, 1'b1);
    drive_frame(200, 1'b0, 1'b0);
    wait_drain("ovf");
    check("ovf_run", 32'(last_run), 32'd64);
    check("ovf_flag", 32'(overflow), 32'd1);
    repeat (40) @(negedge clk);
    check("ovf_sticky", 32'(overflow), 32'd1);
    check("ovf_no_frame3", 32'(exp_q.size()), 32'd0);

    // Reset while overflow is set, then reset mid-drain
    i_rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_clears_ovf", 32'(overflow), 32'd0);
    i_rst = 1'b0;
    drive_frame(500, 1'b0, 1'b1);
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_re == DATA_W'(510)) begin
        hit = 1'b1;
        break;
      end
    end
    check("middrain_reached_n10", 32'(hit), 32'd1);
    #1;
    i_rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("middrain_valid", 32'(out_valid), 32'd0);
    check("middrain_ovf", 32'(overflow), 32'd0);
    check("middrain_re", 32'(out_re), 32'd0);
    i_rst = 1'b0;
    repeat (5) @(negedge clk);
    check("middrain_stays_idle", 32'(out_valid), 32'd0);
    drive_frame(40, 1'b0, 1'b1);
    check_latency("fresh");
    wait_drain("fresh");
    check("fresh_run", 32'(last_run), 32'd32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
